fir_out_decim: RTL and testbench

- Downstream consumer of the FIR filter's 24-bit output stream.
- Keeps one of every DECIM samples, then rounds, shifts and saturates each kept sample to OUT_W bits.
- Buffers results in a small FIFO.
- Presents them on an AXI-Stream master with full backpressure, so audio/DAC sinks downstream can stall without losing samples.

---
 rtl/fir_out_decim.sv | 111 +++++++++++
 tb/tb_fir_out_decim.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_out_decim.sv
// Decimate, round, shift and saturate a signed FIR output stream into a small
// AXI-Stream FIFO. Define FIR_DECIM_SATCNT_EN to add the sat_count port and counter.
module fir_out_decim #(
  parameter int IN_W       = 24,
  parameter int OUT_W      = 16,
  parameter int SHIFT      = 8,
  parameter int DECIM      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic [IN_W-1:0]  s_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic [OUT_W-1:0] m_axis_tdata
`ifdef FIR_DECIM_SATCNT_EN
  ,
  output logic [15:0]      sat_count
`endif
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both
  // high; valid never waits on ready, and ready here is a plain register.

  localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int EW   = IN_W + 1;
  localparam logic signed [EW-1:0] SAT_MAX = EW'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [EW-1:0] SAT_MIN = ~SAT_MAX;

  logic [PH_W-1:0]        phase_q, phase_d;
  logic                   st1_vld_q, st1_vld_d;
  logic signed [EW-1:0]   st1_data_q, st1_data_d;
  logic [OUT_W-1:0]       mem_q [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]          count_q, count_d;
  logic                   tready_q, tready_d;

  logic                   accept, keep, push, pop;
  logic                   sat_hi, sat_lo;
  logic signed [EW-1:0]   rounded;
  logic [OUT_W-1:0]       sat_val;

  assign accept = s_axis_tvalid & tready_q;
  assign keep   = accept & (phase_q == '0);
  assign push   = st1_vld_q;
  assign pop    = (count_q != '0) & m_axis_tready;

  always_comb begin
    rounded    = $signed({s_axis_tdata[IN_W-1], s_axis_tdata}) + (EW'(1) << (SHIFT - 1));
    st1_data_d = keep ? (rounded >>> SHIFT) : st1_data_q;
    st1_vld_d  = keep;
    phase_d    = phase_q;
    if (accept) begin
      phase_d = (phase_q == PH_W'(DECIM - 1)) ? '0 : phase_q + 1'b1;
    end
    sat_hi  = st1_data_q > SAT_MAX;
    sat_lo  = st1_data_q < SAT_MIN;
    sat_val = sat_hi ? SAT_MAX[OUT_W-1:0] :
              sat_lo ? SAT_MIN[OUT_W-1:0] : st1_data_q[OUT_W-1:0];
    count_d  = count_q + CW'(push) - CW'(pop);
    // Next-state occupancy keeps ready exact without looking at m_axis_tready combinationally.
    tready_d = (count_d + CW'(st1_vld_d)) < CW'(FIFO_DEPTH);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q    <= '0;
      st1_vld_q  <= 1'b0;
      st1_data_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tready_q   <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      st1_vld_q  <= st1_vld_d;
      st1_data_q <= st1_data_d;
      count_q    <= count_d;
      tready_q   <= tready_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= sat_val;
  end

  assign s_axis_tready = tready_q;
  assign m_axis_tvalid = (count_q != '0);
  assign m_axis_tdata  = m_axis_tvalid ? mem_q[rd_ptr_q] : '0;

`ifdef FIR_DECIM_SATCNT_EN
  logic [15:0] sat_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat_cnt_q <= '0;
    end else if (push && (sat_hi || sat_lo) && (sat_cnt_q != 16'hFFFF)) begin
      sat_cnt_q <= sat_cnt_q + 16'd1;
    end
  end

  assign sat_count = sat_cnt_q;
`endif

endmodule

// File: tb/tb_fir_out_decim.sv
// Bench for fir_out_decim: a DECIM=1 and a DECIM=4 instance share clock and reset,
// checked against an arithmetic reference model and expected-output queues.
module tb_fir_out_decim;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid  [2];
  logic        s_ready  [2];
  logic [23:0] s_data   [2];
  logic        m_valid  [2];
  logic        m_ready  [2];
  logic [15:0] m_data   [2];
`ifdef FIR_DECIM_SATCNT_EN
  logic [15:0] sat_cnt  [2];
`endif

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];
  int          acc_n  [2];
  int          kept_n [2];
  int          out_n  [2];
  bit          held   [2];
  logic [15:0] held_data [2];
  logic [15:0] sat_exp [2];

  always #5 clk = ~clk;

  fir_out_decim #(.DECIM(1)) u_dec1 (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(s_valid[0]), .s_axis_tready(s_ready[0]), .s_axis_tdata(s_data[0]),
    .m_axis_tvalid(m_valid[0]), .m_axis_tready(m_ready[0]), .m_axis_tdata(m_data[0])
`ifdef FIR_DECIM_SATCNT_EN
    , .sat_count(sat_cnt[0])
`endif
  );

  fir_out_decim #(.DECIM(4)) u_dec4 (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(s_valid[1]), .s_axis_tready(s_ready[1]), .s_axis_tdata(s_data[1]),
    .m_axis_tvalid(m_valid[1]), .m_axis_tready(m_ready[1]), .m_axis_tdata(m_data[1])
`ifdef FIR_DECIM_SATCNT_EN
    , .sat_count(sat_cnt[1])
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Round half up at 2^-8, floor, then clamp to 16-bit signed.
  function automatic logic [15:0] model(input logic [23:0] x, output bit sat);
    longint v, q;
    v = longint'($signed(x)) + 128;
    if (v >= 0) q = v / 256;
    else        q = -((-v + 255) / 256);
    sat = 1'b0;
    if (q > 32767)       begin q = 32767;  sat = 1'b1; end
    else if (q < -32768) begin q = -32768; sat = 1'b1; end
    return q[15:0];
  endfunction

  function automatic int dec_of(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  function automatic int q_size(input int k);
    return (k == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  task automatic q_push(input int k, input logic [15:0] v);
    if (k == 0) exp_q0.push_back(v);
    else        exp_q1.push_back(v);
  endtask

  task automatic q_pop(input int k, output logic [15:0] v);
    if (k == 0) v = exp_q0.pop_front();
    else        v = exp_q1.pop_front();
  endtask

  task automatic mon_step(input int k);
    bit          s;
    logic [15:0] e;
    chk($sformatf("tready_vs_occ%0d", k), s_ready[k], q_size(k) < 4);
    if (held[k]) begin
      chk($sformatf("stall_valid%0d", k), m_valid[k], 1);
      chk($sformatf("stall_data%0d", k), m_data[k], held_data[k]);
    end
    if (m_valid[k] && m_ready[k]) begin
      if (q_size(k) == 0) chk($sformatf("spurious_out%0d", k), q_size(k), 1);
      else begin
        q_pop(k, e);
        chk($sformatf("out_data%0d", k), m_data[k], e);
      end
      out_n[k]++;
    end
    held[k]      = m_valid[k] && !m_ready[k];
    held_data[k] = m_data[k];
    if (s_valid[k] && s_ready[k]) begin
      if (acc_n[k] % dec_of(k) == 0) begin
        e = model(s_data[k], s);
        q_push(k, e);
        kept_n[k]++;
        if (s && sat_exp[k] != 16'hFFFF) sat_exp[k]++;
      end
      acc_n[k]++;
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      exp_q0.delete();
      exp_q1.delete();
      for (int k = 0; k < 2; k++) begin
        acc_n[k] = 0; kept_n[k] = 0; out_n[k] = 0;
        held[k] = 1'b0; sat_exp[k] = '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) mon_step(k);
    end
  end

  // Entered and left at posedge+1; returns one step after the accepting edge.
  task automatic push(input int k, input logic [23:0] d);
    int   b;
    logic acc;
    b = 0;
    acc = 1'b0;
    s_valid[k] = 1'b1;
    s_data[k]  = d;
    while (!acc && b < 200) begin
      @(negedge clk);
      acc = s_ready[k];
      @(posedge clk);
      #1;
      b++;
    end
    chk($sformatf("push_timeout%0d", k), acc, 1);
  endtask

  task automatic drain();
    int b;
    m_ready[0] = 1'b1;
    m_ready[1] = 1'b1;
    b = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0 || m_valid[0] || m_valid[1]) && b < 300) begin
      @(posedge clk);
      #1;
      b++;
    end
    chk("drain_timeout", b < 300, 1);
  endtask

  initial begin
    int base;
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      s_valid[k] = 1'b0; s_data[k] = '0; m_ready[k] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_mvalid%0d", k), m_valid[k], 0);
      chk($sformatf("rst_mdata%0d", k), m_data[k], 0);
      chk($sformatf("rst_sready%0d", k), s_ready[k], 0);
    end
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) chk($sformatf("rel_sready%0d", k), s_ready[k], 1);

    // Two-cycle latency on an empty FIFO.
    m_ready[0] = 1'b1;
    push(0, 24'h000180);
    s_valid[0] = 1'b0;
    chk("lat_valid_early", m_valid[0], 0);
    @(posedge clk);
    #1;
    chk("lat_valid", m_valid[0], 1);
    chk("lat_data", m_data[0], 16'h0002);
    @(posedge clk);
    #1;

    // Clamp high, zero, and -1.
    base = out_n[0];
    push(0, 24'h7FFFFF);
    push(0, 24'hFFFF80);
    push(0, 24'hFFFF7F);
    s_valid[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("sat_out_count", out_n[0] - base, 3);
`ifdef FIR_DECIM_SATCNT_EN
    chk("sat_count_d1", sat_cnt[0], sat_exp[0]);
    chk("sat_count_one", sat_cnt[0], 1);
`endif

    // Decimation by 4 of a ramp.
    base = out_n[1];
    m_ready[1] = 1'b1;
    for (int n = 1; n <= 8; n++) push(1, 24'(n << 8));
    s_valid[1] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("decim_out_count", out_n[1] - base, 2);

    // Full stall: ready must drop after four accepts, then all ten drain in order.
    base = out_n[0];
    m_ready[0] = 1'b0;
    for (int i = 0; i < 4; i++) push(0, 24'($urandom));
    chk("stall_tready_drop", s_ready[0], 0);
    s_data[0] = 24'($urandom);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("stall_tready_low", s_ready[0], 0);
    end
    m_ready[0] = 1'b1;
    push(0, s_data[0]);
    for (int i = 0; i < 5; i++) push(0, 24'($urandom));
    s_valid[0] = 1'b0;
    drain();
    chk("stall_out_count", out_n[0] - base, 10);

    // Asynchronous reset with one output pending, then phase restarts at 0.
    m_ready[1] = 1'b0;
    push(1, 24'($urandom));
    push(1, 24'($urandom));
    s_valid[1] = 1'b0;
    chk("rst_mid_pending", m_valid[1], 1);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_mvalid", m_valid[1], 0);
    chk("rst_mid_sready", s_ready[1], 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_rel_sready", s_ready[1], 1);
    m_ready[1] = 1'b1;
    push(1, 24'h001280);
    s_valid[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mid_kept", out_n[1], 1);

    // Sustained input against a toggling sink on both instances.
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          m_ready[0] = (i % 2 == 0);
          m_ready[1] = (i % 2 == 0);
          @(posedge clk);
          #1;
        end
      end
      begin
        for (int i = 0; i < 40; i++) push(0, 24'($urandom));
        s_valid[0] = 1'b0;
      end
      begin
        for (int i = 0; i < 40; i++) push(1, 24'($urandom_range(24'hFFFFFF, 0)));
        s_valid[1] = 1'b0;
      end
    join
    drain();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("final_kept_vs_out%0d", k), out_n[k], kept_n[k]);
      chk($sformatf("final_queue_empty%0d", k), q_size(k), 0);
`ifdef FIR_DECIM_SATCNT_EN
      chk($sformatf("final_sat_count%0d", k), sat_cnt[k], sat_exp[k]);
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
